// File: rtl/regs_arbiter_n.sv
// N-client REQ/ACK arbiter in front of the register block.
// It picks clients by fixed or round-robin priority, registers the transaction, and completes it with an error on a downstream ACK timeout.
module regs_arbiter_n #(
    parameter int N       = 4,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [N-1:0]      REQ_C,
    input  logic [N-1:0]      RNW_C,
    input  logic [N*AW-1:0]   ADDR_C,
    input  logic [N*DW-1:0]   WR_DATA_C,
    output logic [N*DW-1:0]   RD_DATA_C,
    output logic [N-1:0]      ACK_C,
    output logic [N-1:0]      ERR_C,
    output logic              REQUEST,
    output logic              RNW,
    output logic [AW-1:0]     ADDR,
    output logic [DW-1:0]     WR_DATA,
    input  logic [DW-1:0]     RD_DATA,
    input  logic              ACK,
    output logic              BUSY,
    output logic [IDW-1:0]    GRANT_ID
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDW-1:0]  LAST_RST = IDW'(N - 1);

    state_t          r_state, w_state_next;
    logic            r_request, w_request_next;
    logic            r_rnw, w_rnw_next;
    logic [AW-1:0]   r_addr, w_addr_next;
    logic [DW-1:0]   r_wdata, w_wdata_next;
    logic [IDW-1:0]  r_grant, w_grant_next;
    logic [IDW-1:0]  r_last, w_last_next;
    logic [TO_W-1:0] r_cnt, w_cnt_next;
    logic            r_busy;

    logic [IDW-1:0]  w_fix_idx, w_rr_idx, w_winner;
    logic            w_rr_hit;
    logic            w_sel_rnw;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_fin_ok, w_fin_to;

    // Round-robin winner: highest-priority set index above r_last, else wrap to the lowest set index.
    always_comb begin
        w_fix_idx = '0;
        w_rr_idx  = '0;
        w_rr_hit  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (REQ_C[i]) begin
                w_fix_idx = IDW'(i);
                if (IDW'(i) > r_last) begin
                    w_rr_idx = IDW'(i);
                    w_rr_hit = 1'b1;
                end
            end
        end
        w_winner = ((RR_MODE != 0) && w_rr_hit) ? w_rr_idx : w_fix_idx;

        w_sel_rnw   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N; i++) begin
            if (IDW'(i) == w_winner) begin
                w_sel_rnw   = RNW_C[i];
                w_sel_addr  = ADDR_C[i*AW +: AW];
                w_sel_wdata = WR_DATA_C[i*DW +: DW];
            end
        end
    end

    // A downstream ACK beats a timeout that expires in the same cycle.
    assign w_fin_ok = (r_state == S_GRANT) && ACK;
    assign w_fin_to = (r_state == S_GRANT) && !ACK && TO_EN && (r_cnt == TO_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_request_next = r_request;
        w_rnw_next     = r_rnw;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_grant_next   = r_grant;
        w_last_next    = r_last;
        w_cnt_next     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (|REQ_C) begin
                    w_state_next   = S_GRANT;
                    w_request_next = 1'b1;
                    w_rnw_next     = w_sel_rnw;
                    w_addr_next    = w_sel_addr;
                    w_wdata_next   = w_sel_wdata;
                    w_grant_next   = w_winner;
                    w_last_next    = w_winner;
                    w_cnt_next     = '0;
                end
            end
            S_GRANT: begin
                if (w_fin_ok || w_fin_to) begin
                    w_state_next   = S_DONE;
                    w_request_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next   = S_IDLE;
                w_request_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_request <= 1'b0;
            r_rnw     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_grant   <= '0;
            r_last    <= LAST_RST;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_request <= w_request_next;
            r_rnw     <= w_rnw_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_grant   <= w_grant_next;
            r_last    <= w_last_next;
            r_cnt     <= w_cnt_next;
            r_busy    <= (w_state_next != S_IDLE);
        end
    end

    // Per-client completion registers; only the granted client sees ACK/ERR or a data update.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_client
            logic          w_hit;
            logic          r_ack_c;
            logic          r_err_c;
            logic [DW-1:0] r_rd_c;

            assign w_hit = (r_grant == IDW'(gi));

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_ack_c <= 1'b0;
                    r_err_c <= 1'b0;
                    r_rd_c  <= '0;
                end else begin
                    r_ack_c <= w_hit && (w_fin_ok || w_fin_to);
                    r_err_c <= w_hit && w_fin_to;
                    if (w_hit && w_fin_ok) begin
                        r_rd_c <= RD_DATA;
                    end else if (w_hit && w_fin_to) begin
                        r_rd_c <= '1;
                    end
                end
            end

            assign ACK_C[gi]                = r_ack_c;
            assign ERR_C[gi]                = r_err_c;
            assign RD_DATA_C[gi*DW +: DW]   = r_rd_c;
        end
    endgenerate

    assign REQUEST  = r_request;
    assign RNW      = r_rnw;
    assign ADDR     = r_addr;
    assign WR_DATA  = r_wdata;
    assign BUSY     = r_busy;
    assign GRANT_ID = r_grant;

endmodule

// File: tb/tb_regs_arbiter_n.sv
// Directed bench for regs_arbiter_n: a round-robin and a fixed-priority instance
// share all stimulus; each scenario checks the instance it targets.
module tb_regs_arbiter_n;

    logic        clk;
    logic        rst;
    logic [3:0]  req_c;
    logic [3:0]  rnw_c;
    logic [31:0] addr_c;
    logic [31:0] wdata_c;
    logic [7:0]  rd_data;
    logic        ack;

    logic [31:0] rr_rd_data_c, fx_rd_data_c;
    logic [3:0]  rr_ack_c, fx_ack_c, rr_err_c, fx_err_c;
    logic        rr_request, fx_request, rr_rnw, fx_rnw, rr_busy, fx_busy;
    logic [7:0]  rr_addr, fx_addr, rr_wdata, fx_wdata;
    logic [1:0]  rr_grant, fx_grant;

    int n_checks = 0;
    int n_fail   = 0;

    regs_arbiter_n #(.N(4), .AW(8), .DW(8), .RR_MODE(1), .TIMEOUT(8), .TO_W(8)) dut_rr (
        .CLK(clk), .RESET(rst), .REQ_C(req_c), .RNW_C(rnw_c), .ADDR_C(addr_c),
        .WR_DATA_C(wdata_c), .RD_DATA_C(rr_rd_data_c), .ACK_C(rr_ack_c), .ERR_C(rr_err_c),
        .REQUEST(rr_request), .RNW(rr_rnw), .ADDR(rr_addr), .WR_DATA(rr_wdata),
        .RD_DATA(rd_data), .ACK(ack), .BUSY(rr_busy), .GRANT_ID(rr_grant)
    );

    regs_arbiter_n #(.N(4), .AW(8), .DW(8), .RR_MODE(0), .TIMEOUT(8), .TO_W(8)) dut_fx (
        .CLK(clk), .RESET(rst), .REQ_C(req_c), .RNW_C(rnw_c), .ADDR_C(addr_c),
        .WR_DATA_C(wdata_c), .RD_DATA_C(fx_rd_data_c), .ACK_C(fx_ack_c), .ERR_C(fx_err_c),
        .REQUEST(fx_request), .RNW(fx_rnw), .ADDR(fx_addr), .WR_DATA(fx_wdata),
        .RD_DATA(rd_data), .ACK(ack), .BUSY(fx_busy), .GRANT_ID(fx_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_c = '0; rnw_c = '0; addr_c = '0; wdata_c = '0;
        ack = 1'b0; rd_data = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (rr_request !== 1'b0 || rr_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got req=%0b busy=%0b expected 0 0", rr_request, rr_busy);
        end
        n_checks++;
        if (rr_ack_c !== 4'b0 || rr_err_c !== 4'b0) begin
            n_fail++; $display("FAIL reset_ackerr: got ack=%b err=%b expected 0000 0000", rr_ack_c, rr_err_c);
        end
        n_checks++;
        if (rr_grant !== 2'd0 || rr_rd_data_c !== 32'h0) begin
            n_fail++; $display("FAIL reset_grant_data: got id=%0d rd=%h expected 0 00000000", rr_grant, rr_rd_data_c);
        end
        n_checks++;
        if (rr_addr !== 8'h0 || rr_wdata !== 8'h0 || rr_rnw !== 1'b0) begin
            n_fail++; $display("FAIL reset_bus: got addr=%h wd=%h rnw=%0b expected 00 00 0", rr_addr, rr_wdata, rr_rnw);
        end
        $display("txn reset: outputs checked after reset");
    endtask

    task automatic test_single_read();
        do_reset();
        req_c = 4'b0100; rnw_c = 4'b0100; addr_c[23:16] = 8'h10;
        tick();
        n_checks++;
        if (rr_request !== 1'b1 || rr_addr !== 8'h10 || rr_rnw !== 1'b1 || rr_grant !== 2'd2) begin
            n_fail++; $display("FAIL single_fwd: got req=%0b addr=%h rnw=%0b id=%0d expected 1 10 1 2",
                               rr_request, rr_addr, rr_rnw, rr_grant);
        end
        tick();
        ack = 1'b1; rd_data = 8'hA5;
        n_checks++;
        if (rr_ack_c !== 4'b0000 || rr_request !== 1'b1) begin
            n_fail++; $display("FAIL single_wait: got ack_c=%b req=%0b expected 0000 1", rr_ack_c, rr_request);
        end
        tick();
        ack = 1'b0; rd_data = 8'h00; req_c = 4'b0000;
        n_checks++;
        if (rr_ack_c !== 4'b0100 || rr_err_c !== 4'b0000 || rr_rd_data_c[23:16] !== 8'hA5) begin
            n_fail++; $display("FAIL single_done: got ack_c=%b err_c=%b rd=%h expected 0100 0000 a5",
                               rr_ack_c, rr_err_c, rr_rd_data_c[23:16]);
        end
        n_checks++;
        if (rr_request !== 1'b0 || rr_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_done_ctrl: got req=%0b busy=%0b expected 0 1", rr_request, rr_busy);
        end
        tick();
        n_checks++;
        if (rr_ack_c !== 4'b0000 || rr_busy !== 1'b0 || rr_rd_data_c[23:16] !== 8'hA5) begin
            n_fail++; $display("FAIL single_after: got ack_c=%b busy=%0b rd=%h expected 0000 0 a5",
                               rr_ack_c, rr_busy, rr_rd_data_c[23:16]);
        end
        $display("txn single_read: client 2 addr 10 data a5");
    endtask

    task automatic test_fixed_priority();
        do_reset();
        req_c = 4'b1010; rnw_c = 4'b1010; addr_c = 32'h33_00_11_00; ack = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rd_data = 8'h60 + 8'(t);
            tick();
            tick();
            n_checks++;
            if (fx_ack_c !== 4'b0010 || fx_grant !== 2'd1 || fx_rd_data_c[15:8] !== 8'h60 + 8'(t)) begin
                n_fail++; $display("FAIL fixed_client1_%0d: got ack_c=%b id=%0d rd=%h expected 0010 1 %h",
                                   t, fx_ack_c, fx_grant, fx_rd_data_c[15:8], 8'h60 + 8'(t));
            end
            tick();
            $display("txn fixed: granted client %0d", fx_grant);
        end
        req_c = 4'b1000;
        tick();
        n_checks++;
        if (fx_addr !== 8'h33 || fx_grant !== 2'd3) begin
            n_fail++; $display("FAIL fixed_client3_fwd: got addr=%h id=%0d expected 33 3", fx_addr, fx_grant);
        end
        tick();
        n_checks++;
        if (fx_ack_c !== 4'b1000) begin
            n_fail++; $display("FAIL fixed_client3_ack: got ack_c=%b expected 1000", fx_ack_c);
        end
        ack = 1'b0; req_c = 4'b0000;
        tick();
        $display("txn fixed: client 3 granted after client 1 released");
    endtask

    // Downstream answers in the first REQUEST cycle, giving the minimum 3-cycle cadence.
    task automatic test_round_robin();
        logic [1:0] exp_id;
        do_reset();
        req_c = 4'b1111; rnw_c = 4'b1111; ack = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_id  = 2'(t % 4);
            rd_data = 8'h40 + 8'(t);
            tick();
            n_checks++;
            if (rr_ack_c !== 4'b0000 || rr_grant !== exp_id) begin
                n_fail++; $display("FAIL rr_grant_%0d: got ack_c=%b id=%0d expected 0000 %0d", t, rr_ack_c, rr_grant, exp_id);
            end
            tick();
            n_checks++;
            if (rr_ack_c !== (4'b0001 << exp_id) || rr_rd_data_c[exp_id*8 +: 8] !== 8'h40 + 8'(t)) begin
                n_fail++; $display("FAIL rr_ack_%0d: got ack_c=%b rd=%h expected %b %h", t, rr_ack_c,
                                   rr_rd_data_c[exp_id*8 +: 8], 4'b0001 << exp_id, 8'h40 + 8'(t));
            end
            tick();
            n_checks++;
            if (rr_ack_c !== 4'b0000) begin
                n_fail++; $display("FAIL rr_gap_%0d: got ack_c=%b expected 0000", t, rr_ack_c);
            end
            $display("txn round_robin: completion %0d for client %0d", t, exp_id);
        end
        ack = 1'b0; req_c = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        int n_req;
        do_reset();
        req_c = 4'b0001; rnw_c = 4'b0000; addr_c[7:0] = 8'h80; wdata_c[7:0] = 8'h3C;
        tick();
        n_checks++;
        if (rr_addr !== 8'h80 || rr_wdata !== 8'h3C || rr_rnw !== 1'b0) begin
            n_fail++; $display("FAIL timeout_fwd: got addr=%h wd=%h rnw=%0b expected 80 3c 0", rr_addr, rr_wdata, rr_rnw);
        end
        n_req = 0;
        for (int c = 0; c < 20 && rr_request; c++) begin
            n_req++;
            tick();
        end
        req_c = 4'b0000;
        n_checks++;
        if (n_req != 8) begin
            n_fail++; $display("FAIL timeout_len: got %0d REQUEST cycles expected 8", n_req);
        end
        n_checks++;
        if (rr_ack_c !== 4'b0001 || rr_err_c !== 4'b0001 || rr_rd_data_c[7:0] !== 8'hFF) begin
            n_fail++; $display("FAIL timeout_done: got ack_c=%b err_c=%b rd=%h expected 0001 0001 ff",
                               rr_ack_c, rr_err_c, rr_rd_data_c[7:0]);
        end
        tick();
        n_checks++;
        if (rr_ack_c !== 4'b0000 || rr_err_c !== 4'b0000 || rr_busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after: got ack_c=%b err_c=%b busy=%0b expected 0000 0000 0",
                               rr_ack_c, rr_err_c, rr_busy);
        end
        $display("txn timeout: client 0 write addr 80 ended with error");
    endtask

    task automatic test_boundary();
        do_reset();
        req_c = 4'b0010; rnw_c = 4'b0010; addr_c[15:8] = 8'h22;
        tick();
        for (int c = 0; c < 7; c++) tick();
        n_checks++;
        if (rr_request !== 1'b1 || rr_ack_c !== 4'b0000) begin
            n_fail++; $display("FAIL boundary_cycle8: got req=%0b ack_c=%b expected 1 0000", rr_request, rr_ack_c);
        end
        ack = 1'b1; rd_data = 8'h5A;
        tick();
        ack = 1'b0; req_c = 4'b0000;
        n_checks++;
        if (rr_ack_c !== 4'b0010 || rr_err_c !== 4'b0000 || rr_rd_data_c[15:8] !== 8'h5A) begin
            n_fail++; $display("FAIL boundary_done: got ack_c=%b err_c=%b rd=%h expected 0010 0000 5a",
                               rr_ack_c, rr_err_c, rr_rd_data_c[15:8]);
        end
        tick();
        ack = 1'b1;
        tick();
        n_checks++;
        if (rr_ack_c !== 4'b0000 || rr_busy !== 1'b0 || rr_request !== 1'b0) begin
            n_fail++; $display("FAIL stray_ack: got ack_c=%b busy=%0b req=%0b expected 0000 0 0",
                               rr_ack_c, rr_busy, rr_request);
        end
        ack = 1'b0;
        tick();
        n_checks++;
        if (rr_ack_c !== 4'b0000) begin
            n_fail++; $display("FAIL stray_ack_next: got ack_c=%b expected 0000", rr_ack_c);
        end
        $display("txn boundary: ack in 8th cycle completed, stray ack ignored");
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_c = 4'b0001;
        tick();
        tick();
        n_checks++;
        if (rr_busy !== 1'b1 || rr_request !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got busy=%0b req=%0b expected 1 1", rr_busy, rr_request);
        end
        rst = 1'b1; ack = 1'b1;
        tick();
        rst = 1'b0; ack = 1'b0; req_c = 4'b0110;
        n_checks++;
        if (rr_request !== 1'b0 || rr_busy !== 1'b0 || rr_ack_c !== 4'b0000 || rr_grant !== 2'd0) begin
            n_fail++; $display("FAIL midrst_state: got req=%0b busy=%0b ack_c=%b id=%0d expected 0 0 0000 0",
                               rr_request, rr_busy, rr_ack_c, rr_grant);
        end
        tick();
        n_checks++;
        if (rr_ack_c !== 4'b0000 || rr_grant !== 2'd1 || rr_request !== 1'b1) begin
            n_fail++; $display("FAIL midrst_regrant: got ack_c=%b id=%0d req=%0b expected 0000 1 1",
                               rr_ack_c, rr_grant, rr_request);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0; req_c = 4'b0000;
        n_checks++;
        if (rr_ack_c !== 4'b0010) begin
            n_fail++; $display("FAIL midrst_ack: got ack_c=%b expected 0010", rr_ack_c);
        end
        tick();
        $display("txn reset_mid: aborted client 0, client 1 granted first");
    endtask

    initial begin
        rst = 1'b1; req_c = '0; rnw_c = '0; addr_c = '0; wdata_c = '0; ack = 1'b0; rd_data = '0;
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
